lsu_hs: RTL and testbench

Parametrised, handshaked load-store unit for the pipelined core; successor to the single-cycle LSU. A request channel (valid/ready) accepts one load or store per cycle. A one-deep response channel returns extended load data plus error flags one cycle after acceptance. The block holds a synchronous-read DMEM, N generic memory-mapped output registers and a synchronised input port. Misaligned and illegal accesses are reported instead of being silently zeroed.

---
 rtl/lsu_pkg.sv | 58 +++++
 rtl/lsu_sync_ram.sv | 29 ++
 rtl/lsu_hs.sv | 225 ++++++++++++++++++++++
 tb/tb_lsu_hs.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the handshaked load-store unit: RV32I funct3
// encodings, address-map constants, region/state enums and lane helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] IO_BASE    = 32'h1000_0000;
    localparam int unsigned BLOCK_SIZE = 4096;

    typedef enum logic [1:0] {
        REG_DMEM,
        REG_OUT,
        REG_IN,
        REG_NONE
    } region_e;

    typedef enum logic {
        S_IDLE,
        S_RESP
    } state_e;

    // Select the byte/half addressed by lo and extend it as funct3 asks.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lo,
                                                input logic [2:0]  funct3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_BU:   r = {24'h0, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_HU:   r = {16'h0, h};
            F3_W:    r = word;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // Byte enables for a store of size funct3[1:0] at byte offset lo.
    function automatic logic [3:0] store_be(input logic [1:0] lo,
                                            input logic [1:0] size);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_sync_ram.sv
// Single-port synchronous-read data memory with per-byte write enables.
// Written in the plain template that maps onto block RAM; no reset.
module lsu_sync_ram #(
    parameter int unsigned WORDS = 512,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          re,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   q
);

    logic [31:0] mem [WORDS];

    // Byte-lane writes and registered read; q holds whenever re is low.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/lsu_hs.sv
// Handshaked load-store unit: valid/ready request channel, one-deep
// response channel, DMEM, N_OUT output registers and a synchronised input.
// Optional build macro LSU_UNMAPPED_ERR_EN: when defined, unmapped accesses
// and stores to the input register report o_rsp_err instead of being
// silently dropped / returning zero.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | no response outstanding, o_rsp_* forced to zero
// S_RESP | response for the last accepted request is on o_rsp_*
module lsu_hs
    import lsu_pkg::*;
#(
    parameter int unsigned DMEM_WORDS  = 512,
    parameter int unsigned N_OUT       = 5,
    parameter logic [31:0] IN_ADDR     = 32'h1001_0000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic [31:0]          i_req_addr,
    input  logic [31:0]          i_req_wdata,
    input  logic                 i_req_we,
    input  logic [2:0]           i_req_funct3,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [31:0]          o_rsp_rdata,
    output logic                 o_rsp_misalign,
    output logic                 o_rsp_err,
    output logic [N_OUT*32-1:0]  o_io_out,
    input  logic [31:0]          i_io_in
);

    localparam int unsigned AW       = $clog2(DMEM_WORDS);
    localparam int unsigned OW       = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int unsigned BLK_BITS = $clog2(BLOCK_SIZE);
    localparam int unsigned PAGE_W   = 32 - BLK_BITS;

    localparam logic [31:0]       DMEM_BYTES = 32'(DMEM_WORDS) << 2;
    localparam logic [PAGE_W-1:0] OUT_PAGE   = IO_BASE[31:BLK_BITS];
    localparam logic [PAGE_W-1:0] IN_PAGE    = IN_ADDR[31:BLK_BITS];
    localparam logic [PAGE_W-1:0] N_OUT_P    = PAGE_W'(N_OUT);

    state_e            state;
    state_e            state_nx;
    logic              rsp_valid;
    logic              req_ready;
    logic              accept;

    logic [PAGE_W-1:0] page;
    logic [PAGE_W-1:0] out_off;
    logic [OW-1:0]     out_idx;
    region_e           region;
    logic [1:0]        size;
    logic              legal_f3;
    logic              misalign;
    logic              err;
    logic              wr_ok;
    logic [3:0]        be;
    logic [31:0]       wdata_lane;

    logic [3:0]        ram_we;
    logic              ram_re;
    logic [31:0]       ram_q;

    logic [31:0]       out_reg [N_OUT];
    logic [31:0]       sync_q  [SYNC_STAGES];
    logic [31:0]       sync_in;

    logic              r_zero;
    logic              r_from_ram;
    logic              r_mis;
    logic              r_err;
    logic [1:0]        r_lo;
    logic [2:0]        r_f3;
    logic [31:0]       r_io_word;
    logic [31:0]       rsp_word;

    assign rsp_valid = (state == S_RESP);
    assign req_ready = !rsp_valid || i_rsp_ready;
    assign accept    = i_req_valid && req_ready;
    assign sync_in   = sync_q[SYNC_STAGES-1];

    // Address decode into a region plus the output-register index.
    always_comb begin
        page    = i_req_addr[31:BLK_BITS];
        out_off = page - OUT_PAGE;
        out_idx = out_off[OW-1:0];
        if (i_req_addr < DMEM_BYTES) begin
            region = REG_DMEM;
        end else if (page == IN_PAGE) begin
            region = REG_IN;
        end else if (out_off < N_OUT_P) begin
            region = REG_OUT;
        end else begin
            region = REG_NONE;
        end
    end

    // funct3 legality, alignment, error and store lane shaping.
    always_comb begin
        size = i_req_funct3[1:0];
        if (i_req_we) begin
            legal_f3 = (i_req_funct3 inside {F3_B, F3_H, F3_W});
        end else begin
            legal_f3 = (i_req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end
        misalign = legal_f3 &&
                   (((size == 2'b01) && i_req_addr[0]) ||
                    ((size == 2'b10) && (i_req_addr[1:0] != 2'b00)));
        err = !legal_f3;
`ifdef LSU_UNMAPPED_ERR_EN
        if ((region == REG_NONE) || (i_req_we && (region == REG_IN))) begin
            err = 1'b1;
        end
`endif
        wr_ok = accept && i_req_we && !misalign && !err;
        be    = store_be(i_req_addr[1:0], size);
        case (size)
            2'b00:   wdata_lane = {4{i_req_wdata[7:0]}};
            2'b01:   wdata_lane = {2{i_req_wdata[15:0]}};
            default: wdata_lane = i_req_wdata;
        endcase
    end

    assign ram_we = (wr_ok && (region == REG_DMEM)) ? be : 4'b0000;
    assign ram_re = accept && !i_req_we && (region == REG_DMEM);

    lsu_sync_ram #(
        .WORDS (DMEM_WORDS)
    ) u_dmem (
        .clk   (i_clk),
        .re    (ram_re),
        .we    (ram_we),
        .addr  (i_req_addr[AW+1:2]),
        .wdata (wdata_lane),
        .q     (ram_q)
    );

    // Output registers take byte-enabled writes at the accept edge.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int k = 0; k < N_OUT; k++) begin
                out_reg[k] <= 32'h0;
            end
        end else if (wr_ok && (region == REG_OUT)) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    out_reg[out_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
                end
            end
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_io_out
        assign o_io_out[32*k +: 32] = out_reg[k];
    end

    // Synchroniser chain for the external input port.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 32'h0;
            end
        end else begin
            sync_q[0] <= i_io_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Capture everything the response needs so it stays stable in a stall.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_zero     <= 1'b1;
            r_from_ram <= 1'b0;
            r_mis      <= 1'b0;
            r_err      <= 1'b0;
            r_lo       <= 2'b00;
            r_f3       <= 3'b000;
            r_io_word  <= 32'h0;
        end else if (accept) begin
            r_zero     <= i_req_we || misalign || err || (region == REG_NONE);
            r_from_ram <= (region == REG_DMEM);
            r_mis      <= misalign;
            r_err      <= err;
            r_lo       <= i_req_addr[1:0];
            r_f3       <= i_req_funct3;
            r_io_word  <= (region == REG_OUT) ? out_reg[out_idx] : sync_in;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = S_RESP;
            S_RESP: if (i_rsp_ready && !accept) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Response outputs, forced to zero while idle.
    always_comb begin
        rsp_word       = r_from_ram ? ram_q : r_io_word;
        o_rsp_valid    = rsp_valid;
        o_req_ready    = req_ready;
        o_rsp_rdata    = (rsp_valid && !r_zero) ? load_extend(rsp_word, r_lo, r_f3) : 32'h0;
        o_rsp_misalign = rsp_valid && r_mis;
        o_rsp_err      = rsp_valid && r_err;
    end

endmodule

// File: tb/tb_lsu_hs.sv
// Self-checking bench for lsu_hs. Expected responses are queued when a
// request is accepted and compared when the response handshake completes.
module tb_lsu_hs;

    localparam int N_OUT = 5;

    logic               i_clk = 1'b0;
    logic               i_reset = 1'b0;
    logic               i_req_valid = 1'b0;
    logic               o_req_ready;
    logic [31:0]        i_req_addr = '0;
    logic [31:0]        i_req_wdata = '0;
    logic               i_req_we = 1'b0;
    logic [2:0]         i_req_funct3 = '0;
    logic               o_rsp_valid;
    logic               i_rsp_ready = 1'b1;
    logic [31:0]        o_rsp_rdata;
    logic               o_rsp_misalign;
    logic               o_rsp_err;
    logic [N_OUT*32-1:0] o_io_out;
    logic [31:0]        i_io_in = '0;

    lsu_hs #(
        .DMEM_WORDS  (512),
        .N_OUT       (N_OUT),
        .IN_ADDR     (32'h1001_0000),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_addr     (i_req_addr),
        .i_req_wdata    (i_req_wdata),
        .i_req_we       (i_req_we),
        .i_req_funct3   (i_req_funct3),
        .o_rsp_valid    (o_rsp_valid),
        .i_rsp_ready    (i_rsp_ready),
        .o_rsp_rdata    (o_rsp_rdata),
        .o_rsp_misalign (o_rsp_misalign),
        .o_rsp_err      (o_rsp_err),
        .o_io_out       (o_io_out),
        .i_io_in        (i_io_in)
    );

    always #5 i_clk = ~i_clk;

`ifdef LSU_UNMAPPED_ERR_EN
    localparam logic UNMAP_ERR = 1'b1;
`else
    localparam logic UNMAP_ERR = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        err;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    logic last_acc;
    int   last_ncyc;
    int   nassert = 0;
    int   nfail = 0;

    // One clock: sample at negedge (pop/compare response, note accept),
    // then advance to just after the rising edge and queue the accept.
    task automatic cycle();
        exp_t e;
        logic acc;
        logic pop;
        @(negedge i_clk);
        acc = i_req_valid & o_req_ready;
        pop = o_rsp_valid & i_rsp_ready;
        if (pop) begin
            nassert++;
            if (sb.size() == 0) begin
                nfail++;
                $display("FAIL unexpected_rsp: got rdata=%h, required no response", o_rsp_rdata);
            end else begin
                e = sb.pop_front();
                if ({o_rsp_rdata, o_rsp_misalign, o_rsp_err} !== {e.rdata, e.mis, e.err}) begin
                    nfail++;
                    $display("FAIL %s: got rdata=%h mis=%b err=%b, required rdata=%h mis=%b err=%b",
                             e.tag, o_rsp_rdata, o_rsp_misalign, o_rsp_err, e.rdata, e.mis, e.err);
                end
            end
        end
        @(posedge i_clk);
        #1;
        last_acc = acc;
        if (acc) sb.push_back(pend);
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] erd,
                         input logic emis, input logic eerr, input string tag);
        int n;
        i_req_we     = we;
        i_req_funct3 = f3;
        i_req_addr   = addr;
        i_req_wdata  = wdata;
        pend = '{rdata: erd, mis: emis, err: eerr, tag: tag};
        i_req_valid  = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 40);
        if (!last_acc) begin
            nassert++;
            nfail++;
            $display("FAIL %s_accept_timeout: got no accept in %0d cycles, required accept", tag, n);
        end
        last_ncyc   = n;
        i_req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            cycle();
            n++;
        end
        if (sb.size() > 0) begin
            nassert++;
            nfail++;
            $display("FAIL drain_timeout: got %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        #23;
        nassert++;
        if ({o_rsp_valid, o_req_ready, o_rsp_rdata, o_rsp_misalign, o_rsp_err} !== {1'b0, 1'b1, 32'h0, 1'b0, 1'b0}) begin
            nfail++;
            $display("FAIL reset_rsp: got valid=%b ready=%b rdata=%h mis=%b err=%b, required 0 1 0 0 0",
                     o_rsp_valid, o_req_ready, o_rsp_rdata, o_rsp_misalign, o_rsp_err);
        end
        nassert++;
        if (o_io_out !== '0) begin
            nfail++;
            $display("FAIL reset_io_out: got %h, required 0", o_io_out);
        end
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_word();
        issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, "sw_0x10");
        issue(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, "lw_0x10");
        nassert++;
        if (o_rsp_valid !== 1'b1) begin
            nfail++;
            $display("FAIL lw_latency: got rsp_valid=%b one cycle after accept, required 1", o_rsp_valid);
        end
        drain();
    endtask

    task automatic test_byte();
        issue(1'b1, 3'b000, 32'h13, 32'h0000_0080, 32'h0, 1'b0, 1'b0, "sb_0x13");
        issue(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b0, "lb_0x13");
        issue(1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_0080, 1'b0, 1'b0, "lbu_0x13");
        issue(1'b0, 3'b100, 32'h12, 32'h0, 32'h0000_00AD, 1'b0, 1'b0, "lbu_0x12");
        issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h80AD_BEEF, 1'b0, 1'b0, "lw_after_sb");
        drain();
    endtask

    task automatic test_half();
        issue(1'b1, 3'b010, 32'h20, 32'h1122_3344, 32'h0, 1'b0, 1'b0, "sw_0x20");
        issue(1'b1, 3'b001, 32'h22, 32'h0000_8001, 32'h0, 1'b0, 1'b0, "sh_0x22");
        issue(1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF_8001, 1'b0, 1'b0, "lh_0x22");
        issue(1'b0, 3'b101, 32'h22, 32'h0, 32'h0000_8001, 1'b0, 1'b0, "lhu_0x22");
        issue(1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 1'b1, 1'b0, "lw_misalign_0x22");
        issue(1'b1, 3'b001, 32'h21, 32'h0000_FFFF, 32'h0, 1'b1, 1'b0, "sh_misalign_0x21");
        issue(1'b0, 3'b010, 32'h20, 32'h0, 32'h8001_3344, 1'b0, 1'b0, "lw_0x20_unchanged");
        issue(1'b0, 3'b001, 32'h21, 32'h0, 32'h0, 1'b1, 1'b0, "lh_misalign_0x21");
        drain();
    endtask

    task automatic test_io();
        issue(1'b1, 3'b010, 32'h1000_2000, 32'h1234_5678, 32'h0, 1'b0, 1'b0, "sw_out2");
        issue(1'b1, 3'b000, 32'h1000_2001, 32'h0000_00AA, 32'h0, 1'b0, 1'b0, "sb_out2");
        drain();
        nassert++;
        if (o_io_out[95:64] !== 32'h1234_AA78) begin
            nfail++;
            $display("FAIL io_out2: got %h, required 1234aa78", o_io_out[95:64]);
        end
        nassert++;
        if ({o_io_out[159:96], o_io_out[63:0]} !== '0) begin
            nfail++;
            $display("FAIL io_out_others: got %h, required 0", {o_io_out[159:96], o_io_out[63:0]});
        end
        issue(1'b0, 3'b010, 32'h1000_2000, 32'h0, 32'h1234_AA78, 1'b0, 1'b0, "lw_out2");
        issue(1'b0, 3'b010, 32'h1000_2FFC, 32'h0, 32'h1234_AA78, 1'b0, 1'b0, "lw_out2_alias");
        issue(1'b0, 3'b000, 32'h1000_2001, 32'h0, 32'hFFFF_FFAA, 1'b0, 1'b0, "lb_out2");
        drain();
        i_io_in = 32'h0000_0005;
        cycle();
        cycle();
        issue(1'b0, 3'b010, 32'h1001_0000, 32'h0, 32'h0000_0005, 1'b0, 1'b0, "lw_in");
        i_io_in = 32'h8765_0005;
        cycle();
        cycle();
        issue(1'b0, 3'b001, 32'h1001_0002, 32'h0, 32'hFFFF_8765, 1'b0, 1'b0, "lh_in_hi");
        issue(1'b1, 3'b010, 32'h1001_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, UNMAP_ERR, "sw_in");
        issue(1'b0, 3'b010, 32'h1001_0000, 32'h0, 32'h8765_0005, 1'b0, 1'b0, "lw_in_after_sw");
        drain();
    endtask

    task automatic test_backpressure();
        i_rsp_ready = 1'b0;
        issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h80AD_BEEF, 1'b0, 1'b0, "bp_first");
        i_req_we     = 1'b0;
        i_req_funct3 = 3'b010;
        i_req_addr   = 32'h20;
        pend = '{rdata: 32'h8001_3344, mis: 1'b0, err: 1'b0, tag: "bp_second"};
        i_req_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            nassert++;
            if ({last_acc, o_req_ready, o_rsp_valid, o_rsp_rdata} !== {1'b0, 1'b0, 1'b1, 32'h80AD_BEEF}) begin
                nfail++;
                $display("FAIL bp_stall%0d: got acc=%b ready=%b valid=%b rdata=%h, required 0 0 1 80adbeef",
                         i, last_acc, o_req_ready, o_rsp_valid, o_rsp_rdata);
            end
        end
        i_rsp_ready = 1'b1;
        cycle();
        nassert++;
        if (last_acc !== 1'b1) begin
            nfail++;
            $display("FAIL bp_release_accept: got acc=%b, required 1", last_acc);
        end
        i_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 3'b100, 32'h10 + i, 32'h0, (i == 3) ? 32'h80 : ((i == 2) ? 32'hAD : ((i == 1) ? 32'hBE : 32'hEF)),
                  1'b0, 1'b0, "b2b_lbu");
            nassert++;
            if (last_ncyc !== 1) begin
                nfail++;
                $display("FAIL b2b_throughput%0d: got %0d cycles per accept, required 1", i, last_ncyc);
            end
        end
        drain();
    endtask

    task automatic test_errors();
        issue(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b0, 1'b1, "ld_f3_011");
        issue(1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, "st_f3_100");
        issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h80AD_BEEF, 1'b0, 1'b0, "lw_after_bad_st");
        issue(1'b0, 3'b010, 32'h2000_0000, 32'h0, 32'h0, 1'b0, UNMAP_ERR, "lw_unmapped");
        issue(1'b0, 3'b010, 32'h1000_5000, 32'h0, 32'h0, 1'b0, UNMAP_ERR, "lw_out5_unmapped");
        issue(1'b1, 3'b010, 32'h1000_5000, 32'h1111_1111, 32'h0, 1'b0, UNMAP_ERR, "sw_out5_unmapped");
        drain();
        nassert++;
        if (o_io_out[159:128] !== 32'h0) begin
            nfail++;
            $display("FAIL out4_untouched: got %h, required 0", o_io_out[159:128]);
        end
    endtask

    task automatic test_reset_mid_stall();
        i_rsp_ready = 1'b0;
        issue(1'b1, 3'b010, 32'h1000_0000, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0, "sw_out0_stall");
        nassert++;
        if ({o_rsp_valid, o_io_out[31:0]} !== {1'b1, 32'hCAFE_F00D}) begin
            nfail++;
            $display("FAIL stall_before_reset: got valid=%b out0=%h, required 1 cafef00d",
                     o_rsp_valid, o_io_out[31:0]);
        end
        #2;
        i_reset = 1'b0;
        #1;
        nassert++;
        if ({o_rsp_valid, o_req_ready} !== 2'b01) begin
            nfail++;
            $display("FAIL async_reset_rsp: got valid=%b ready=%b, required 0 1", o_rsp_valid, o_req_ready);
        end
        nassert++;
        if (o_io_out !== '0) begin
            nfail++;
            $display("FAIL async_reset_io: got %h, required 0", o_io_out);
        end
        sb.delete();
        @(posedge i_clk);
        #3;
        i_reset     = 1'b1;
        i_rsp_ready = 1'b1;
        @(posedge i_clk);
        #1;
        issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h80AD_BEEF, 1'b0, 1'b0, "dmem_kept_over_reset");
        drain();
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_io();
        test_backpressure();
        test_errors();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
